swervolf_sevenseg: RTL and testbench

Memory-mapped controller for the Nexys A7 eight-digit seven-segment display; it sits downstream of the SweRVolf Wishbone peripheral bus in the `clk_core` domain and drives the board's `AN` and `{CA..CG}` pins. Software writes eight hex nibbles and a per-digit enable mask. The block time-multiplexes the digits with a fixed refresh period and inserts a blanking guard between digits to suppress ghosting. Digit data is latched per slot, so a digit never changes while it is lit.

---
 rtl/swervolf_sevenseg_pkg.sv | 18 +
 rtl/seg7_decode.sv | 11 +
 rtl/swervolf_sevenseg.sv | 141 ++++++++++++++
 tb/tb_swervolf_sevenseg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swervolf_sevenseg_pkg.sv
// Shared definitions for the SweRVolf seven-segment display controller:
// register map, scan FSM states and the active-low {CA..CG} glyph table.
package swervolf_sevenseg_pkg;

    localparam logic [1:0] SS_DATA   = 2'd0;
    localparam logic [1:0] SS_EN     = 2'd1;
    localparam logic [1:0] SS_STATUS = 2'd2;

    typedef enum logic {SS_BLANK, SS_SHOW} ss_state_e;

    localparam logic [6:0] SS_DECODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern {CA..CG}.
module seg7_decode
    import swervolf_sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SS_DECODE[nib];

endmodule

// File: rtl/swervolf_sevenseg.sv
// Wishbone-mapped eight-digit seven-segment scanner with a blanking guard
// between digits; digit data is latched per slot so a lit digit never tears.
module swervolf_sevenseg
    import swervolf_sevenseg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [7:0]  AN,
    output logic [6:0]  Digits_Bits
);

    localparam int unsigned DIV         = CLK_FREQ_HZ / SCAN_HZ;
    localparam int unsigned SHOW_CYCLES = DIV - BLANK_CYCLES;
    localparam int          CW          = $clog2(DIV + 1);

    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES);

    if (DIV < BLANK_CYCLES + 2) begin : g_div_check
        $error("swervolf_sevenseg: CLK_FREQ_HZ/SCAN_HZ must be at least BLANK_CYCLES+2");
    end

    logic [31:0]   data_q;
    logic [7:0]    en_q;
    ss_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    cur_nib;
    logic          cur_en;
    logic [6:0]    seg_code;
    logic          req;
    logic [31:0]   rd_data;

    seg7_decode u_decode (
        .nib (cur_nib),
        .seg (seg_code)
    );

    // One ack per request: a held request re-arms only after ack drops.
    assign req = i_wb_cyc & i_wb_stb & ~o_wb_ack;

    // NOTE: every variable driven here gets a default first; a case arm that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            SS_DATA:   rd_data = data_q;
            SS_EN:     rd_data = {24'b0, en_q};
            SS_STATUS: rd_data = {28'b0, state == SS_BLANK, idx};
            default:   rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes the slot latch see the
    // pre-write DATA/EN when a bus write commits on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            data_q   <= '0;
            en_q     <= '0;
        end else begin
            o_wb_ack <= req;
            if (req) begin
                o_wb_rdt <= rd_data;
                if (i_wb_we) begin
                    case (i_wb_adr)
                        SS_DATA: begin
                            for (int b = 0; b < 4; b++) begin
                                if (i_wb_sel[b]) data_q[8*b +: 8] <= i_wb_dat[8*b +: 8];
                            end
                        end
                        SS_EN:   if (i_wb_sel[0]) en_q <= i_wb_dat[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs are computed from the pre-edge state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SS_BLANK;
            cnt         <= BLANK_LOAD;
            idx         <= '0;
            cur_nib     <= '0;
            cur_en      <= 1'b0;
            AN          <= 8'hFF;
            Digits_Bits <= 7'h7F;
        end else begin
            case (state)
                SS_BLANK: begin
                    if (cnt == CW'(1)) begin
                        state   <= SS_SHOW;
                        cnt     <= SHOW_LOAD;
                        cur_nib <= data_q[{idx, 2'b00} +: 4];
                        cur_en  <= en_q[idx];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SS_SHOW: begin
                    if (cnt == CW'(1)) begin
                        state <= SS_BLANK;
                        cnt   <= BLANK_LOAD;
                        idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= SS_BLANK;
                    cnt   <= BLANK_LOAD;
                end
            endcase

            if (state == SS_SHOW) begin
                AN          <= ~(8'(cur_en) << idx);
                Digits_Bits <= seg_code;
            end else begin
                AN          <= 8'hFF;
                Digits_Bits <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_swervolf_sevenseg.sv
// Directed bench for swervolf_sevenseg: display expectations go through a
// scoreboard queue popped every falling edge; bus reads are checked in place.
module tb_swervolf_sevenseg;

    localparam int unsigned CLK_FREQ_HZ  = 1000;
    localparam int unsigned SCAN_HZ      = 100;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int SLOT   = 10;
    localparam int BLANKN = 2;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_EN     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    localparam logic [6:0] CODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        int         slot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [7:0]  AN;
    logic [6:0]  Digits_Bits;

    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_req = 0;
    int   n_ack = 0;
    exp_t sb[$];

    swervolf_sevenseg #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .SCAN_HZ      (SCAN_HZ),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .AN          (AN),
        .Digits_Bits (Digits_Bits)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (o_wb_ack) n_ack++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert ({AN, Digits_Bits} === {e.an, e.seg}) else begin
                n_bad++;
                $error("FAIL slot%0d_k%0d: got AN=%h seg=%b, expected AN=%h seg=%b",
                       e.slot, cyc, AN, Digits_Bits, e.an, e.seg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc != target && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc != target) begin
            n_cmp++;
            n_bad++;
            $error("FAIL wait_cyc: got %0d expected %0d", cyc, target);
        end
    endtask

    // Slot s covers the outputs after edges 10s+1 .. 10s+10.
    task automatic expect_slot(input int s, input logic [7:0] an, input logic [6:0] seg);
        wait_cyc(SLOT * s + 1);
        for (int i = 0; i < BLANKN; i++) sb.push_back('{an: 8'hFF, seg: 7'h7F, slot: s});
        for (int i = BLANKN; i < SLOT; i++) sb.push_back('{an: an, seg: seg, slot: s});
    endtask

    task automatic wb_xfer(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdt);
        int g = 0;
        i_wb_adr = adr;
        i_wb_we  = we;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        n_req++;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!o_wb_ack && g < 4);
        check("ack_high", 32'(o_wb_ack), 32'd1);
        rdt      = o_wb_rdt;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge clk);
        #1;
        check("ack_low", 32'(o_wb_ack), 32'd0);
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused_rdt;
        wb_xfer(adr, 1'b1, dat, sel, unused_rdt);
    endtask

    task automatic wb_read(input logic [1:0] adr, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(adr, 1'b0, 32'h0, 4'h0, d);
        check(tag, d, exp);
    endtask

    initial begin
        int idx;
        int g;

        // Reset held five cycles
        repeat (5) begin
            @(negedge clk);
            check("rst_an", 32'(AN), 32'hFF);
            check("rst_seg", 32'(Digits_Bits), 32'h7F);
            check("rst_ack", 32'(o_wb_ack), 32'd0);
            check("rst_rdt", o_wb_rdt, 32'd0);
        end
        rst = 1'b0;

        expect_slot(0, 8'hFF, CODE[0]);
        wb_read(A_STATUS, "status_blank", 32'h8);

        // Full scan with wrap 7 -> 0
        wb_write(A_DATA, 32'h76543210, 4'hF);
        wb_write(A_EN, 32'hFF, 4'h1);
        for (int s = 1; s <= 8; s++) expect_slot(s, ~(8'd1 << (s % 8)), CODE[s % 8]);

        // Enable mask; this write lands on slot 8's latch edge, which keeps EN=FF
        wb_write(A_EN, 32'h05, 4'h1);
        for (int s = 9; s <= 16; s++) begin
            idx = s % 8;
            expect_slot(s, (idx == 0 || idx == 2) ? ~(8'd1 << idx) : 8'hFF, CODE[idx]);
        end

        // Tear-free update mid-SHOW of digit 3
        wb_write(A_EN, 32'hFF, 4'h1);
        expect_slot(17, 8'hFD, CODE[1]);
        expect_slot(18, 8'hFB, CODE[2]);
        expect_slot(19, 8'hF7, CODE[3]);
        wait_cyc(195);
        wb_write(A_DATA, 32'hFFFFFFFF, 4'hF);
        for (int s = 20; s <= 27; s++) expect_slot(s, ~(8'd1 << (s % 8)), CODE[15]);

        // Byte lanes, readback, ignored addresses
        wb_write(A_DATA, 32'h0, 4'hF);
        wb_write(A_DATA, 32'hAABBCCDD, 4'b0010);
        wb_read(A_DATA, "data_lane1", 32'h0000CC00);
        wb_write(A_EN, 32'hFFFFFF3C, 4'b0001);
        wb_read(A_EN, "en_readback", 32'h0000003C);
        wb_write(A_RSVD, 32'hFFFFFFFF, 4'hF);
        wb_write(A_STATUS, 32'hFFFFFFFF, 4'hF);
        wb_read(A_RSVD, "rsvd_zero", 32'h0);
        wb_read(A_DATA, "data_unchanged", 32'h0000CC00);

        // Async reset during digit 5's SHOW
        wait_cyc(295);
        check("pre_rst_an", 32'(AN), 32'hDF);
        check("pre_rst_seg", 32'(Digits_Bits), 32'(CODE[0]));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_an", 32'(AN), 32'hFF);
        check("async_rst_seg", 32'(Digits_Bits), 32'h7F);
        repeat (3) begin
            @(negedge clk);
            check("hold_rst_an", 32'(AN), 32'hFF);
            check("hold_rst_seg", 32'(Digits_Bits), 32'h7F);
        end
        rst = 1'b0;

        expect_slot(0, 8'hFF, CODE[0]);
        wb_read(A_STATUS, "status_restart", 32'h8);
        wb_write(A_DATA, 32'h89ABCDEF, 4'hF);
        wb_write(A_EN, 32'hFF, 4'h1);
        expect_slot(1, 8'hFD, CODE[14]);
        expect_slot(2, 8'hFB, CODE[13]);

        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("ack_count", 32'(n_ack), 32'(n_req));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
